slv_guard_cfg_regs: RTL
=======================

// Module: slv_guard_cfg_regs
// PURPOSE
//  Register-bus responder holding the runtime configuration and status of the slave guard.
//  Serves reg_bus reads/writes from the SoC config master. Drives enable and the eight
//  phase budgets into the monitor core. Captures the monitor's timeout events as sticky
//  W1C flags, a saturating event count and an interrupt.
// PARAMETERS
//  AddrWidth   32  reg_bus address width
//  CntWidth    10  width of unit-length / wlast->bvalid budgets and of ERR_COUNT
//  HsCntWidth   4  width of valid->ready handshake budgets
// PORTS
//  clk_i           in   1          clock
//  rst_ni          in   1          async reset, active low
//  reg_addr_i      in   AddrWidth  byte address
//  reg_wdata_i     in   32         write data
//  reg_wstrb_i     in   4          byte enables
//  reg_write_i     in   1          1=write 0=read
//  reg_valid_i     in   1          request valid
//  reg_rdata_o     out  32         read data
//  reg_error_o     out  1          access error, valid with ready
//  reg_ready_o     out  1          transfer complete
//  timeout_evt_i   in   8          1-cycle pulses: [0]aw [1]wunit [2]w [3]wlast-b [4]b [5]ar [6]runit [7]r
//  guard_en_o      out  1          CTRL.ENABLE
//  irq_o           out  1          IRQ_EN & |STATUS
//  budget_*_o      out  Hs/Cnt     aw_vld_rdy,w_vld_rdy,b_vld_rdy,ar_vld_rdy (Hs); unit_w,wlast_bvld,unit_r (Cnt); r_vld_rdy (Hs)
// BEHAVIOUR
//  Map (word aligned; fields LSB-aligned, unused bits read 0, write ignored):
//   0x00 CTRL [8]ENABLE [0]IRQ_EN; 0x04 AW_VR; 0x08 UNIT_W; 0x0C W_VR; 0x10 WLAST_BV; 0x14 B_VR
//   0x18 AR_VR; 0x1C UNIT_R; 0x20 R_VR; 0x24 STATUS[7:0] W1C; 0x28 ERR_COUNT RO; 0x2C ERR_COUNT clear (write any)
//  FSM IDLE->RESP:
//   - IDLE: ready=0; on valid, register addr/write/wdata/wstrb; go RESP.
//   - RESP: ready=1 for exactly one cycle with rdata/error; effects commit on this cycle; go IDLE.
//   - Latency: ready 1 cycle after valid is sampled. Back-to-back requests are accepted every 2 cycles.
//   - A valid still high in the IDLE cycle after RESP is treated as a new request.
//   - Requester holds request stable until ready.
//  Writes: byte-granular via wstrb. wstrb=0 is a legal no-op with error=0.
//  Error=1, rdata=0, no state change:
//   - addr[1:0]!=0.
//   - addr>0x2C.
//   - Write to 0x04-0x20 while ENABLE=1 (budgets locked while guard runs).
//   - Write to 0x28.
//   - CTRL is always writable.
//  Reads return current values; error=0.
//  STATUS[i]:
//   - Set on timeout_evt_i[i]. Cleared by W1C.
//   - Set and clear on the same cycle: set wins.
//  ERR_COUNT:
//   - Adds popcount(timeout_evt_i) per cycle, saturates at 2**CntWidth-1 (no wrap).
//   - Clear via 0x2C and a same-cycle event: result = popcount of that cycle's events.
//  Events are recorded regardless of ENABLE.
//  irq_o is registered: follows STATUS/IRQ_EN one cycle after update.
//  Reset (async, any state incl. mid-RESP):
//   - FSM=IDLE, ready=0, error=0, rdata=0.
//   - CTRL=0, all budgets=0, STATUS=0, ERR_COUNT=0.
//   - guard_en_o=0, irq_o=0, budget_*_o=0.
//   - A transfer interrupted by reset is dropped, never completed.
// TESTING
//  1 Write 0x100 to 0x00 -> ready 1 cycle later, error=0, guard_en_o=1. Read 0x00 -> 0x100.
//  2 ENABLE=0, write 0xF to 0x04 and 0x3FF to 0x08 -> budget_aw_vld_rdy_o=0xF,
//    budget_unit_w_o=0x3FF. Read 0x04 -> 0xF.
//  3 ENABLE=1, write 0x5 to 0x04 -> error=1, budget unchanged.
//    Read 0x30 -> error=1, rdata=0. Write to 0x06 -> error=1.
//  4 Pulse timeout_evt_i=0x81, IRQ_EN=1 -> STATUS=0x81, ERR_COUNT=2, irq_o=1.
//    W1C 0x01 in the same cycle as event[0] -> STATUS stays 0x81.
//    Then W1C 0x81 -> STATUS=0, irq_o=0.
//  5 Hold timeout_evt_i=0xFF for 200 cycles (CntWidth=10) -> ERR_COUNT=1023, stays 1023.
//    Write 0x2C -> 0.
//  6 Assert rst_ni low during RESP -> ready=0 immediately.
//    All regs read back 0 after reset; next transfer completes normally.

Source files
------------

// File: rtl/slv_guard_cfg_regs_if.sv
// Register-bus bundle between the SoC config master and the slave-guard register block.
// The master drives the request and holds it until ready; the slave answers with rdata/error.
interface slv_guard_cfg_regs_if #(
  parameter int AddrWidth = 32
);
  logic [AddrWidth-1:0] addr;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 write;
  logic                 valid;
  logic [31:0]          rdata;
  logic                 error;
  logic                 ready;

  modport master (
    output addr, wdata, wstrb, write, valid,
    input  rdata, error, ready
  );

  modport slave (
    input  addr, wdata, wstrb, write, valid,
    output rdata, error, ready
  );
endinterface

// File: rtl/slv_guard_cfg_regs.sv
// Configuration and status registers of the slave guard: enable, eight phase budgets,
// sticky W1C timeout flags, a saturating timeout-event counter and a registered interrupt.
module slv_guard_cfg_regs #(
  parameter int AddrWidth  = 32,
  parameter int CntWidth   = 10,
  parameter int HsCntWidth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  slv_guard_cfg_regs_if.slave   reg_bus,
  input  logic [7:0]            timeout_evt_i,
  output logic                  guard_en_o,
  output logic                  irq_o,
  output logic [HsCntWidth-1:0] budget_aw_vld_rdy_o,
  output logic [HsCntWidth-1:0] budget_w_vld_rdy_o,
  output logic [HsCntWidth-1:0] budget_b_vld_rdy_o,
  output logic [HsCntWidth-1:0] budget_ar_vld_rdy_o,
  output logic [CntWidth-1:0]   budget_unit_w_o,
  output logic [CntWidth-1:0]   budget_wlast_bvld_o,
  output logic [CntWidth-1:0]   budget_unit_r_o,
  output logic [HsCntWidth-1:0] budget_r_vld_rdy_o
);

  typedef enum logic {IDLE, RESP} state_e;

  // Word index = addr[5:2]; indices 1..8 are the budgets in address order.
  localparam logic [3:0] IdxCtrl     = 4'd0;
  localparam logic [3:0] IdxStatus   = 4'd9;
  localparam logic [3:0] IdxCount    = 4'd10;
  localparam logic [3:0] IdxCountClr = 4'd11;

  state_e              state_q;
  logic [3:0]          idx_q;
  logic                write_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                ready_q, error_q;
  logic [31:0]         rdata_q;

  logic                enable_q, irq_en_q, irq_q;
  logic [CntWidth-1:0] budget_q [8];
  logic [7:0]          status_q;
  logic [CntWidth-1:0] count_q;

  // Budgets 1 (unit_w), 3 (wlast_bvld) and 6 (unit_r) are CntWidth wide, the rest HsCntWidth.
  function automatic logic [CntWidth-1:0] field_mask(input logic [2:0] sel);
    if (sel == 3'd1 || sel == 3'd3 || sel == 3'd6) return {CntWidth{1'b1}};
    return CntWidth'({HsCntWidth{1'b1}});
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  logic [3:0]  idx_c;
  logic [2:0]  bsel_c;
  logic        is_budget_c, err_c;
  logic [31:0] rdata_c;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // (a missing default infers a latch).
  always_comb begin
    idx_c       = reg_bus.addr[5:2];
    bsel_c      = 3'(idx_c - 4'd1);
    is_budget_c = (idx_c >= 4'd1) && (idx_c <= 4'd8);
    err_c       = (reg_bus.addr[1:0] != 2'b00)
               || (reg_bus.addr > AddrWidth'(32'h2C))
               || (reg_bus.write && is_budget_c && enable_q)
               || (reg_bus.write && idx_c == IdxCount);
    rdata_c     = '0;
    if (!reg_bus.write && !err_c) begin
      if (idx_c == IdxCtrl)        rdata_c = {23'b0, enable_q, 7'b0, irq_en_q};
      else if (is_budget_c)        rdata_c = 32'(budget_q[bsel_c]);
      else if (idx_c == IdxStatus) rdata_c = {24'b0, status_q};
      else if (idx_c == IdxCount)  rdata_c = 32'(count_q);
    end
  end

  logic                commit;
  logic [31:0]         wmask, ctrl_wr;
  logic [7:0]          status_clr;
  logic                count_clr;
  logic [CntWidth:0]   count_sum;
  logic [CntWidth-1:0] count_nxt;

  always_comb begin
    commit     = (state_q == RESP) && write_q && !error_q;
    wmask      = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    ctrl_wr    = merge({23'b0, enable_q, 7'b0, irq_en_q}, wdata_q, wmask);
    status_clr = (commit && idx_q == IdxStatus) ? (wdata_q[7:0] & wmask[7:0]) : 8'h00;
    count_clr  = commit && (idx_q == IdxCountClr) && (|wstrb_q);
    // A clear coinciding with events restarts the count from this cycle's events.
    count_sum  = {1'b0, count_clr ? {CntWidth{1'b0}} : count_q}
               + (CntWidth+1)'($countones(timeout_evt_i));
    count_nxt  = count_sum[CntWidth] ? {CntWidth{1'b1}} : count_sum[CntWidth-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (reg_bus.valid) begin
          state_q <= RESP;
          ready_q <= 1'b1;
          error_q <= err_c;
          rdata_q <= rdata_c;
          idx_q   <= idx_c;
          write_q <= reg_bus.write;
          wdata_q <= reg_bus.wdata;
          wstrb_q <= reg_bus.wstrb;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      status_q <= '0;
      count_q  <= '0;
      // NOTE: the budget array is only eight flop words driving live outputs, so it is
      // reset like any other register (large RAM-style arrays would not be).
      for (int i = 0; i < 8; i++) budget_q[i] <= '0;
    end else begin
      status_q <= (status_q & ~status_clr) | timeout_evt_i;
      count_q  <= count_nxt;
      irq_q    <= irq_en_q & (|status_q);
      if (commit && idx_q == IdxCtrl) begin
        enable_q <= ctrl_wr[8];
        irq_en_q <= ctrl_wr[0];
      end
      for (int i = 0; i < 8; i++) begin
        if (commit && idx_q == 4'(i + 1))
          budget_q[i] <= CntWidth'(merge(32'(budget_q[i]), wdata_q, wmask)) & field_mask(3'(i));
      end
    end
  end

  assign reg_bus.ready = ready_q;
  assign reg_bus.error = error_q;
  assign reg_bus.rdata = rdata_q;

  assign guard_en_o          = enable_q;
  assign irq_o               = irq_q;
  assign budget_aw_vld_rdy_o = HsCntWidth'(budget_q[0]);
  assign budget_unit_w_o     = budget_q[1];
  assign budget_w_vld_rdy_o  = HsCntWidth'(budget_q[2]);
  assign budget_wlast_bvld_o = budget_q[3];
  assign budget_b_vld_rdy_o  = HsCntWidth'(budget_q[4]);
  assign budget_ar_vld_rdy_o = HsCntWidth'(budget_q[5]);
  assign budget_unit_r_o     = budget_q[6];
  assign budget_r_vld_rdy_o  = HsCntWidth'(budget_q[7]);

endmodule
